// File: rtl/gate_exerciser_if.sv
// Bus between the gate exerciser and whatever drives/observes it: run control,
// stimulus operands, the gate block's results and the run verdict.
interface gate_exerciser_if;
    logic       start;
    logic [6:0] gate_res;
    logic       a;
    logic       b;
    logic       busy;
    logic       done;
    logic       pass;
    logic [2:0] err_cnt;
    logic [1:0] first_fail_vec;
    logic [6:0] first_fail_mask;

    modport master (
        output start, gate_res,
        input  a, b, busy, done, pass, err_cnt, first_fail_vec, first_fail_mask
    );

    modport slave (
        input  start, gate_res,
        output a, b, busy, done, pass, err_cnt, first_fail_vec, first_fail_mask
    );
endinterface

// File: rtl/gate_exerciser.sv
// Walks {a,b} through 00,01,10,11, lets the gate block settle, and checks its seven outputs.
// Define GATE_EXERCISER_ERRLOG_EN to keep the vector and mismatch mask of the first failure.
//
// state  | meaning
// IDLE   | waiting for start after reset
// SETTLE | holding the current vector while the gate block settles
// CHECK  | comparing gate_res against the expected results for one cycle
// DONE   | run finished; verdict held until the next start
module gate_exerciser #(
    parameter int unsigned SETTLE_CYC = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    gate_exerciser_if.slave bus_if
);
    typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

    localparam logic [7:0] CNT_LOAD = 8'(SETTLE_CYC - 1);

    state_t     state_q;
    logic [1:0] vec_q;
    logic [7:0] cnt_q;
    logic [2:0] err_cnt_q;
    logic       busy_q;
    logic       done_q;
    logic       pass_q;

    logic [6:0] exp_res;
    logic [6:0] mismatch;
    logic       vec_fail;
    logic [2:0] err_cnt_d;
    logic       run_start;

    // bit order: and, or, not(a), nand, nor, xor, xnor
    always_comb begin
        exp_res   = {~(vec_q[1] ^ vec_q[0]), vec_q[1] ^ vec_q[0], ~(vec_q[1] | vec_q[0]),
                     ~(vec_q[1] & vec_q[0]), ~vec_q[1], vec_q[1] | vec_q[0], vec_q[1] & vec_q[0]};
        mismatch  = bus_if.gate_res ^ exp_res;
        vec_fail  = |mismatch;
        err_cnt_d = err_cnt_q + {2'b00, vec_fail};
        run_start = ((state_q == IDLE) || (state_q == DONE)) && bus_if.start;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            vec_q     <= 2'd0;
            cnt_q     <= 8'd0;
            err_cnt_q <= 3'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (bus_if.start) begin
                        state_q   <= SETTLE;
                        vec_q     <= 2'd0;
                        cnt_q     <= CNT_LOAD;
                        err_cnt_q <= 3'd0;
                        busy_q    <= 1'b1;
                        done_q    <= 1'b0;
                        pass_q    <= 1'b0;
                    end
                end
                SETTLE: begin
                    if (cnt_q == 8'd0) begin
                        state_q <= CHECK;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                CHECK: begin
                    err_cnt_q <= err_cnt_d;
                    if (vec_q != 2'd3) begin
                        vec_q   <= vec_q + 2'd1;
                        cnt_q   <= CNT_LOAD;
                        state_q <= SETTLE;
                    end else begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (err_cnt_d == 3'd0);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef GATE_EXERCISER_ERRLOG_EN
    logic [1:0] ff_vec_q;
    logic [6:0] ff_mask_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff_vec_q  <= 2'd0;
            ff_mask_q <= 7'd0;
        end else if (run_start) begin
            ff_vec_q  <= 2'd0;
            ff_mask_q <= 7'd0;
        end else if ((state_q == CHECK) && (err_cnt_q == 3'd0) && vec_fail) begin
            ff_vec_q  <= vec_q;
            ff_mask_q <= mismatch;
        end
    end

    assign bus_if.first_fail_vec  = ff_vec_q;
    assign bus_if.first_fail_mask = ff_mask_q;
`else
    assign bus_if.first_fail_vec  = 2'd0;
    assign bus_if.first_fail_mask = 7'd0;
`endif

    assign bus_if.a       = vec_q[1];
    assign bus_if.b       = vec_q[0];
    assign bus_if.busy    = busy_q;
    assign bus_if.done    = done_q;
    assign bus_if.pass    = pass_q;
    assign bus_if.err_cnt = err_cnt_q;
endmodule

// File: tb/tb_gate_exerciser.sv
// Directed bench for gate_exerciser: a behavioural gate block with injectable stuck bits,
// one instance at SETTLE_CYC=4 and one at SETTLE_CYC=1.
module tb_gate_exerciser;
    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    logic [6:0] stuck0;
    logic [6:0] stuck1;

    gate_exerciser_if mi ();
    gate_exerciser_if si ();

    gate_exerciser #(.SETTLE_CYC(4)) dut  (.clk(clk), .rst_n(rst_n), .bus_if(mi.slave));
    gate_exerciser #(.SETTLE_CYC(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus_if(si.slave));

    function automatic logic [6:0] good_gates(input logic a, input logic b);
        return {~(a ^ b), a ^ b, ~(a | b), ~(a & b), ~a, a | b, a & b};
    endfunction

    always_comb mi.gate_res = (good_gates(mi.a, mi.b) & ~stuck0) | stuck1;
    always_comb si.gate_res = good_gates(si.a, si.b);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Starts a run on the SETTLE_CYC=4 instance; optionally re-pulses start at edge mid.
    task automatic do_run(input int mid, output int done_edge, output int seq_bad);
        done_edge = -1;
        seq_bad   = 0;
        @(negedge clk);
        mi.start = 1'b1;
        @(posedge clk); #1;
        if ({mi.a, mi.b} !== 2'd0 || mi.busy !== 1'b1) seq_bad++;
        for (int k = 1; k <= 60; k++) begin
            mi.start = (k == mid);
            @(posedge clk); #1;
            if (mi.done === 1'b1) begin
                done_edge = k;
                break;
            end
            if ({mi.a, mi.b} !== 2'(k / 5) || mi.busy !== 1'b1) seq_bad++;
        end
        mi.start = 1'b0;
    endtask

    task automatic test_reset;
        rst_n    = 1'b0;
        mi.start = 1'b0;
        si.start = 1'b0;
        stuck0   = 7'd0;
        stuck1   = 7'd0;
        #12;
        checks++;
        if ({mi.a, mi.b, mi.busy, mi.done, mi.pass, mi.err_cnt, mi.first_fail_vec, mi.first_fail_mask} !== 17'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected all zero",
                     {mi.a, mi.b, mi.busy, mi.done, mi.pass, mi.err_cnt, mi.first_fail_vec, mi.first_fail_mask});
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (mi.busy !== 1'b0 || mi.done !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b done=%b expected 0 0", mi.busy, mi.done);
        end
    endtask

    task automatic test_good_run;
        int de, sb;
        do_run(0, de, sb);
        checks++;
        if (de !== 20) begin errors++; $display("FAIL good_done_edge: got %0d expected 20", de); end
        checks++;
        if (sb !== 0) begin errors++; $display("FAIL good_sequence: %0d bad cycles expected 0", sb); end
        checks++;
        if (mi.pass !== 1'b1 || mi.err_cnt !== 3'd0 || mi.busy !== 1'b0) begin
            errors++;
            $display("FAIL good_verdict: pass=%b err_cnt=%0d busy=%b expected 1 0 0", mi.pass, mi.err_cnt, mi.busy);
        end
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (mi.done !== 1'b1 || {mi.a, mi.b} !== 2'b11 || mi.pass !== 1'b1) begin
            errors++;
            $display("FAIL done_hold: done=%b ab=%b pass=%b expected 1 11 1", mi.done, {mi.a, mi.b}, mi.pass);
        end
    endtask

    task automatic test_xor_stuck0;
        int de, sb;
        stuck0 = 7'b0100000;
        do_run(0, de, sb);
        checks++;
        if (de !== 20 || sb !== 0) begin
            errors++;
            $display("FAIL xor_stuck_timing: done_edge=%0d bad=%0d expected 20 0", de, sb);
        end
        checks++;
        if (mi.err_cnt !== 3'd2 || mi.pass !== 1'b0) begin
            errors++;
            $display("FAIL xor_stuck_verdict: err_cnt=%0d pass=%b expected 2 0", mi.err_cnt, mi.pass);
        end
        checks++;
`ifdef GATE_EXERCISER_ERRLOG_EN
        if (mi.first_fail_vec !== 2'b01 || mi.first_fail_mask !== 7'b0100000) begin
            errors++;
            $display("FAIL xor_stuck_log: vec=%b mask=%b expected 01 0100000", mi.first_fail_vec, mi.first_fail_mask);
        end
`else
        if (mi.first_fail_vec !== 2'b00 || mi.first_fail_mask !== 7'd0) begin
            errors++;
            $display("FAIL xor_stuck_log: vec=%b mask=%b expected 00 0000000", mi.first_fail_vec, mi.first_fail_mask);
        end
`endif
    endtask

    // Leaves the previous faulty run in DONE, then reruns with a clean gate model.
    task automatic test_back_to_back;
        int de, sb;
        stuck0 = 7'd0;
        @(negedge clk);
        mi.start = 1'b1;
        @(posedge clk); #1;
        mi.start = 1'b0;
        checks++;
        if (mi.err_cnt !== 3'd0 || mi.done !== 1'b0 || mi.busy !== 1'b1) begin
            errors++;
            $display("FAIL restart_clear: err_cnt=%0d done=%b busy=%b expected 0 0 1", mi.err_cnt, mi.done, mi.busy);
        end
        de = -1;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk); #1;
            if (mi.done === 1'b1) begin de = k; break; end
        end
        checks++;
        if (de !== 20 || mi.pass !== 1'b1 || mi.err_cnt !== 3'd0) begin
            errors++;
            $display("FAIL restart_run: done_edge=%0d pass=%b err_cnt=%0d expected 20 1 0", de, mi.pass, mi.err_cnt);
        end
        sb = 0;
    endtask

    task automatic test_not_stuck1;
        int de, sb;
        stuck1 = 7'b0000100;
        do_run(0, de, sb);
        stuck1 = 7'd0;
        checks++;
        if (de !== 20 || mi.err_cnt !== 3'd2 || mi.pass !== 1'b0) begin
            errors++;
            $display("FAIL not_stuck: done_edge=%0d err_cnt=%0d pass=%b expected 20 2 0", de, mi.err_cnt, mi.pass);
        end
        checks++;
`ifdef GATE_EXERCISER_ERRLOG_EN
        if (mi.first_fail_vec !== 2'b10 || mi.first_fail_mask !== 7'b0000100) begin
            errors++;
            $display("FAIL not_stuck_log: vec=%b mask=%b expected 10 0000100", mi.first_fail_vec, mi.first_fail_mask);
        end
`else
        if (mi.first_fail_vec !== 2'b00 || mi.first_fail_mask !== 7'd0) begin
            errors++;
            $display("FAIL not_stuck_log: vec=%b mask=%b expected 00 0000000", mi.first_fail_vec, mi.first_fail_mask);
        end
`endif
    endtask

    task automatic test_start_while_busy;
        int de, sb;
        do_run(7, de, sb);
        checks++;
        if (de !== 20 || sb !== 0 || mi.pass !== 1'b1) begin
            errors++;
            $display("FAIL busy_start: done_edge=%0d bad=%0d pass=%b expected 20 0 1", de, sb, mi.pass);
        end
    endtask

    task automatic test_reset_midrun;
        stuck0 = 7'b0100000;
        @(negedge clk);
        mi.start = 1'b1;
        @(posedge clk); #1;
        mi.start = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        checks++;
        if ({mi.a, mi.b} !== 2'b10 || mi.err_cnt !== 3'd1 || mi.busy !== 1'b1) begin
            errors++;
            $display("FAIL pre_abort: ab=%b err_cnt=%0d busy=%b expected 10 1 1", {mi.a, mi.b}, mi.err_cnt, mi.busy);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({mi.a, mi.b} !== 2'b00 || mi.busy !== 1'b0 || mi.err_cnt !== 3'd0 || mi.done !== 1'b0) begin
            errors++;
            $display("FAIL async_abort: ab=%b busy=%b err_cnt=%0d done=%b expected 00 0 0 0",
                     {mi.a, mi.b}, mi.busy, mi.err_cnt, mi.done);
        end
        stuck0 = 7'd0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if ({mi.a, mi.b} !== 2'b00 || mi.busy !== 1'b0 || mi.done !== 1'b0) begin
            errors++;
            $display("FAIL wait_idle: ab=%b busy=%b done=%b expected 00 0 0", {mi.a, mi.b}, mi.busy, mi.done);
        end
    endtask

    task automatic test_settle_one;
        int de, sb;
        de = -1;
        sb = 0;
        @(negedge clk);
        si.start = 1'b1;
        @(posedge clk); #1;
        si.start = 1'b0;
        if ({si.a, si.b} !== 2'd0) sb++;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk); #1;
            if (si.done === 1'b1) begin de = k; break; end
            if ({si.a, si.b} !== 2'(k / 2)) sb++;
        end
        checks++;
        if (de !== 8 || sb !== 0) begin
            errors++;
            $display("FAIL settle1: done_edge=%0d bad=%0d expected 8 0", de, sb);
        end
        checks++;
        if (si.pass !== 1'b1 || si.err_cnt !== 3'd0) begin
            errors++;
            $display("FAIL settle1_verdict: pass=%b err_cnt=%0d expected 1 0", si.pass, si.err_cnt);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_good_run();
        test_xor_stuck0();
        test_back_to_back();
        test_not_stuck1();
        test_start_while_busy();
        test_reset_midrun();
        test_settle_one();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
